msk_sbox_arbiter: RTL

//  Shares one masked bit-sliced S-box pipeline (bp_inv_sbox / bp_aes_sbox_msk_noctrl_noenable)

---
 rtl/msk_sbox_arbiter_if.sv | 25 ++
 rtl/msk_sbox_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/msk_sbox_arbiter_if.sv
// Requester-side handshake bundle for the shared masked S-box arbiter:
// two request ports and the shared response bus.
interface msk_sbox_arbiter_if #(
    parameter int d = 2
);
    logic           req0_valid;
    logic           req0_ready;
    logic [8*d-1:0] req0_data;
    logic           req1_valid;
    logic           req1_ready;
    logic [8*d-1:0] req1_data;
    logic           rsp0_valid;
    logic           rsp1_valid;
    logic [8*d-1:0] rsp_data;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
    );
endinterface

// File: rtl/msk_sbox_arbiter.sv
// Shares one fixed-latency masked S-box pipeline between two requesters.
// Round-robin grant on contention, one PRNG bundle consumed per issued byte,
// each randomness bus delayed to meet its S-box stage, and a tag pipe that
// routes each result back to the port that issued it.
module msk_sbox_arbiter #(
    parameter int d     = 2,
    parameter int LAT   = 4,
    parameter int NRND  = d * (d - 1) / 2,
    parameter int RND_W = 34 * NRND,
    parameter int DLY0  = 0,
    parameter int DLY2  = 1,
    parameter int DLY3  = 2,
    parameter int DLY4  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    msk_sbox_arbiter_if.slave    bus,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [RND_W-1:0]     rnd_in,
    output logic [8*d-1:0]       sbox_in,
    input  logic [8*d-1:0]       sbox_out,
    output logic [9*NRND-1:0]    rnd_bus0,
    output logic [3*NRND-1:0]    rnd_bus2,
    output logic [4*NRND-1:0]    rnd_bus3,
    output logic [18*NRND-1:0]   rnd_bus4,
    output logic                 busy
);

    // Bundle layout {bus4, bus3, bus2, bus0}, lowest slice first.
    localparam int BUS_OFF [4] = '{0, 9*NRND, 12*NRND, 16*NRND};
    localparam int BUS_W   [4] = '{9*NRND, 3*NRND, 4*NRND, 18*NRND};
    localparam int BUS_DLY [4] = '{DLY0, DLY2, DLY3, DLY4};

    logic             issue;
    logic             grant;
    logic             last_grant;
    logic [RND_W-1:0] rnd_gated;
    logic [RND_W-1:0] rnd_bus_all;
    logic [LAT-1:0]   tag_v;
    logic [LAT-1:0]   tag_id;

    // Issue decision, round-robin grant and gated data/randomness towards the S-box.
    always_comb begin
        issue          = ~rst & rnd_valid & (bus.req0_valid | bus.req1_valid);
        grant          = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        rnd_ready      = issue;
        bus.req0_ready = issue & ~grant;
        bus.req1_ready = issue & grant;
        sbox_in        = '0;
        if (issue) begin
            sbox_in = grant ? bus.req1_data : bus.req0_data;
        end
        rnd_gated      = issue ? rnd_in : '0;
    end

    // Remember the last granted port; reset value 1 lets port 0 win the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (issue) begin
            last_grant <= grant;
        end
    end

    // Per-bus randomness alignment: zero delay is a straight combinational
    // path, otherwise a shift register loaded with the gated slice each cycle.
    for (genvar k = 0; k < 4; k++) begin : g_rnd
        localparam int OFF = BUS_OFF[k];
        localparam int W   = BUS_W[k];
        localparam int DL  = BUS_DLY[k];
        if (DL == 0) begin : g_comb
            assign rnd_bus_all[OFF +: W] = rnd_gated[OFF +: W];
        end else begin : g_dly
            logic [W-1:0] sr [DL];
            // Shift the stage-aligned randomness every cycle; bubbles carry zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DL; i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= rnd_gated[OFF +: W];
                    for (int unsigned i = 1; i < DL; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end
            assign rnd_bus_all[OFF +: W] = rst ? '0 : sr[DL-1];
        end
    end

    assign rnd_bus0 = rnd_bus_all[BUS_OFF[0] +: BUS_W[0]];
    assign rnd_bus2 = rnd_bus_all[BUS_OFF[1] +: BUS_W[1]];
    assign rnd_bus3 = rnd_bus_all[BUS_OFF[2] +: BUS_W[2]];
    assign rnd_bus4 = rnd_bus_all[BUS_OFF[3] +: BUS_W[3]];

    // Tag pipe tracking valid/requester of each op in flight through the S-box.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Route the S-box result to its requester; in-flight ops are dropped on reset.
    always_comb begin
        bus.rsp0_valid = ~rst & tag_v[LAT-1] & ~tag_id[LAT-1];
        bus.rsp1_valid = ~rst & tag_v[LAT-1] & tag_id[LAT-1];
        bus.rsp_data   = sbox_out;
        busy           = ~rst & (|tag_v);
    end

endmodule
